// File: rtl/regfile_scoreboard.sv
// Register bank with same-cycle write bypass, optional hardwired x0 and per-register busy scoreboard.
// Latency: reads/rbusy combinational, updates on posedge; no backpressure (every write/issue accepted).
module regfile_scoreboard #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]    rbusy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              busy_any
);

  localparam int NREGS = 1 << AW;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_ok;
  logic             iss_ok;

  assign wr_ok  = we && !(ZR && (waddr == '0));
  assign iss_ok = iss_valid && !(ZR && (iss_rd == '0));

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) begin
        regs[waddr] <= wdata;
        busy[waddr] <= 1'b0;
      end
      if (iss_ok) busy[iss_rd] <= 1'b1;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] ra;
    logic          is_zero;
    logic          byp;

    assign ra      = raddr[p*AW +: AW];
    assign is_zero = ZR && (ra == '0);
    assign byp     = wr_ok && (waddr == ra);

    assign rdata[p*XLEN +: XLEN] = is_zero ? '0 : (byp ? wdata : regs[ra]);
    assign rbusy[p]              = !is_zero && !byp && busy[ra];
  end

  assign busy_any = |busy;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard; expectations queued at stimulus time, popped and checked mid-cycle.
module tb_regfile_scoreboard;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 we;
  logic [AW-1:0]        waddr;
  logic [XLEN-1:0]      wdata;
  logic [NRD*AW-1:0]    raddr;
  logic [NRD*XLEN-1:0]  rdata;
  logic [NRD-1:0]       rbusy;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rd;
  logic                 busy_any;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string               tag;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rb;
    logic                ba;
  } exp_t;

  exp_t sb[$];
  logic [XLEN-1:0] mregs [32];

  regfile_scoreboard #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [NRD*XLEN-1:0] rd,
                          input logic [NRD-1:0] rb, input logic ba);
    exp_t e;
    e.tag = tag;
    e.rd  = rd;
    e.rb  = rb;
    e.ba  = ba;
    sb.push_back(e);
  endtask

  task automatic observe();
    exp_t e;
    #2;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (rdata === e.rd) else begin
        errors++;
        $error("FAIL %s rdata: got %h expected %h", e.tag, rdata, e.rd);
      end
      checks++;
      assert (rbusy === e.rb) else begin
        errors++;
        $error("FAIL %s rbusy: got %b expected %b", e.tag, rbusy, e.rb);
      end
      checks++;
      assert (busy_any === e.ba) else begin
        errors++;
        $error("FAIL %s busy_any: got %b expected %b", e.tag, busy_any, e.ba);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [NRD*XLEN-1:0] rd,
                     input logic [NRD-1:0] rb, input logic ba);
    push_exp(tag, rd, rb, ba);
    observe();
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0; iss_valid = 1'b0; iss_rd = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    raddr = {5'd3, 5'd0};
    chk("reset_read", {32'h0, 32'h0}, 2'b00, 1'b0);

    // Writes/issues during reset are dropped, but bypass stays visible.
    we = 1'b1; waddr = 5'd3; wdata = 32'h55; iss_valid = 1'b1; iss_rd = 5'd3;
    chk("reset_bypass", {32'h55, 32'h0}, 2'b00, 1'b0);
    tick();
    idle();
    chk("reset_held", {32'h0, 32'h0}, 2'b00, 1'b0);
    rst = 1'b0;
    tick();
    chk("reset_drop_write", {32'h0, 32'h0}, 2'b00, 1'b0);

    // Write then read, with bypass on port1 in the write cycle.
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr = {5'd5, 5'd3};
    chk("wr_bypass", {32'hDEADBEEF, 32'h0}, 2'b00, 1'b0);
    tick();
    idle();
    raddr = {5'd3, 5'd5};
    chk("wr_readback", {32'h0, 32'hDEADBEEF}, 2'b00, 1'b0);

    // Hardwired zero register.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; iss_valid = 1'b1; iss_rd = 5'd0;
    raddr = {5'd0, 5'd0};
    chk("zero_wr_cycle", {32'h0, 32'h0}, 2'b00, 1'b0);
    tick();
    idle();
    raddr = {5'd5, 5'd0};
    chk("zero_after", {32'hDEADBEEF, 32'h0}, 2'b00, 1'b0);

    // Scoreboard lifecycle on r7.
    iss_valid = 1'b1; iss_rd = 5'd7; raddr = {5'd7, 5'd7};
    chk("iss_same_cycle", {32'h0, 32'h0}, 2'b00, 1'b0);
    tick();
    idle();
    chk("busy_n1", {32'h0, 32'h0}, 2'b11, 1'b1);
    tick();
    chk("busy_n2", {32'h0, 32'h0}, 2'b11, 1'b1);
    tick();
    we = 1'b1; waddr = 5'd7; wdata = 32'h12;
    chk("wb_bypass_n3", {32'h12, 32'h12}, 2'b00, 1'b1);
    tick();
    idle();
    chk("wb_cleared", {32'h12, 32'h12}, 2'b00, 1'b0);

    // Simultaneous set/clear on r9: set wins, data still written.
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick();
    idle();
    raddr = {5'd9, 5'd7};
    chk("r9_busy", {32'h0, 32'h12}, 2'b10, 1'b1);
    we = 1'b1; waddr = 5'd9; wdata = 32'h99; iss_valid = 1'b1; iss_rd = 5'd9;
    chk("r9_setclr_cycle", {32'h99, 32'h12}, 2'b00, 1'b1);
    tick();
    idle();
    chk("r9_set_wins", {32'h99, 32'h12}, 2'b10, 1'b1);
    we = 1'b1; waddr = 5'd9; wdata = 32'h99;
    tick();
    idle();
    chk("r9_retired", {32'h99, 32'h12}, 2'b00, 1'b0);

    // Async reset pulse between edges.
    we = 1'b1; waddr = 5'd4; wdata = 32'hA5; iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    idle();
    raddr = {5'd4, 5'd4};
    chk("r4_before_rst", {32'hA5, 32'hA5}, 2'b11, 1'b1);
    #1 rst = 1'b1;
    chk("r4_async_rst", {32'h0, 32'h0}, 2'b00, 1'b0);
    #1 rst = 1'b0;
    raddr = {5'd5, 5'd4};
    chk("after_rst_pulse", {32'h0, 32'h0}, 2'b00, 1'b0);
    tick();

    // Fill every register through the write port, then read pairs back.
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = $urandom;
      mregs[i] = (i == 0) ? 32'h0 : wdata;
      tick();
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      raddr = {5'(31 - i), 5'(i)};
      chk($sformatf("fill_rd_%0d", i), {mregs[31 - i], mregs[i]}, 2'b00, 1'b0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the core register bank: configurable data width, register count and number of read ports.
- Adds write-to-read bypass, an optional hardwired-zero register 0, and a per-register busy scoreboard for pipeline hazard detection.
- Sits between decode/issue (reads, busy marking) and writeback (register write, busy clear) in the RV32 core.

Parameters:
- XLEN, 32, data width of each register.
- AW, 5, address width; register count NREGS = 2**AW.
- NRD, 2, number of read ports.
- ZERO_REG, 1, if 1 then register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  writeback write enable.
- waddr  in  AW  writeback destination address.
- wdata  in  XLEN  writeback data.
- raddr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rdata  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rbusy  out  NRD  bit i set when the register on port i has a pending producer.
- iss_valid  in  1  issue marks a destination register busy.
- iss_rd  in  AW  destination register being issued.
- busy_any  out  1  OR of all busy bits.

Behaviour:
- Reset (async, rst=1): every register is cleared to 0 and every busy bit to 0, immediately and independent of clk. While reset is held: rdata = 0 on all ports (the bypass still applies if we=1), rbusy = 0, busy_any = 0. Writes and issues are ignored while rst=1.
- "Writable": a write is writable when we=1 and !(ZERO_REG && waddr==0).
- Write: on posedge with a writable write, regs[waddr] <= wdata. Non-writable writes have no effect.
- Read (combinational, zero latency), per port i:
  - If ZERO_REG and raddr_i==0: rdata_i = 0.
  - Else if the write is writable and waddr==raddr_i: rdata_i = wdata (same-cycle bypass).
  - Else: rdata_i = regs[raddr_i].
- All ports are independent; any ports may share an address.
- Scoreboard (busy[NREGS]), on each posedge:
  - A writable write clears busy[waddr].
  - iss_valid=1 sets busy[iss_rd], except iss_rd==0 when ZERO_REG.
  - If both target the same register in one cycle, the set wins (the new producer supersedes the retiring one).
- Writing a non-busy register is legal and leaves busy at 0.
- rbusy_i (combinational) = busy[raddr_i] && !(writable write && waddr==raddr_i). The value being written this cycle is bypassed, so it is not reported busy. A same-cycle issue to raddr_i does not affect rbusy_i until the next cycle.
- rbusy_i is 0 when ZERO_REG and raddr_i==0.
- busy_any reflects registered busy bits only; no bypass term.
- With ZERO_REG=0, register 0 behaves like any other register.
- Reset asserted mid-operation clears state immediately. Operation resumes on the first posedge after rst deasserts.
- No X propagation: every register has a defined value after reset.

Test Plan:
- Reset then read: assert rst, drive raddr = {5'd3, 5'd0} -> rdata = 0, rbusy = 2'b00, busy_any = 0.
- Write then read: we=1, waddr=5, wdata=32'hDEADBEEF for one clock; next cycle raddr port0=5 -> rdata0 = 32'hDEADBEEF. In the same cycle as the write, port1=5 -> rdata1 = 32'hDEADBEEF via bypass.
- Zero register: we=1, waddr=0, wdata=32'hFFFFFFFF, iss_valid=1, iss_rd=0; then read port0=0 -> rdata0 = 0, rbusy0 = 0, busy_any = 0.
- Scoreboard lifecycle:
  - iss_valid=1, iss_rd=7 at clock N -> from N+1, rbusy = 1 on ports reading 7 and busy_any = 1.
  - At N+3: we=1, waddr=7, wdata=32'h12 -> in that cycle rbusy = 0 (bypass) and rdata = 32'h12; after the edge busy[7] = 0 and busy_any = 0.
- Simultaneous set/clear: busy[9]=1; same cycle we=1, waddr=9 and iss_valid=1, iss_rd=9 -> after the edge busy[9] stays 1 and regs[9] = wdata.
- Async reset mid-operation: regs[4]=32'hA5, busy[4]=1; pulse rst between clock edges -> rdata for address 4 = 0 and rbusy = 0 immediately, without waiting for an edge.
